imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 113 +++++++++++
 tb/tb_imem_loader.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - loads a 32-word instruction memory from a byte stream and serves CPU fetches
// Byte stream: one header byte (word count N, 0 means 32), then little-endian 32-bit words.
module imem_loader #(
  parameter int DEPTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic [31:0] pc,
  output logic [31:0] instruction,
  output logic        loading,
  output logic        done,
  output logic [5:0]  word_count
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HEADER = 2'd1,
    S_LOAD   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  lane_q, lane_d;
  logic [23:0] partial_q, partial_d;
  logic [5:0]  word_count_q, word_count_d;
  logic [5:0]  target_q, target_d;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_q [DEPTH];
  logic        xfer;
  logic [4:0]  rd_idx;
  logic [5:0]  word_count_inc;
  logic [26:0] unused_pc_bits;

  assign in_ready       = (state_q == S_HEADER) || (state_q == S_LOAD);
  assign loading        = in_ready;
  assign done           = (state_q == S_DONE);
  assign word_count     = word_count_q;
  assign xfer           = in_valid && in_ready;
  assign word_count_inc = word_count_q + 6'd1;
  assign mem_wdata      = {in_data, partial_q};

  always_comb begin
    state_d      = state_q;
    lane_d       = lane_q;
    partial_d    = partial_q;
    word_count_d = word_count_q;
    target_d     = target_q;
    mem_we       = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d      = S_HEADER;
          word_count_d = 6'd0;
          lane_d       = 2'd0;
        end
      end
      S_HEADER: begin
        if (xfer) begin
          target_d = (in_data[4:0] == 5'd0) ? 6'd32 : {1'b0, in_data[4:0]};
          state_d  = S_LOAD;
          lane_d   = 2'd0;
        end
      end
      S_LOAD: begin
        if (xfer) begin
          case (lane_q)
            2'd0: partial_d[7:0]   = in_data;
            2'd1: partial_d[15:8]  = in_data;
            2'd2: partial_d[23:16] = in_data;
            default: begin
              mem_we       = 1'b1;
              word_count_d = word_count_inc;
              if (word_count_inc == target_q) state_d = S_DONE;
            end
          endcase
          lane_d = lane_q + 2'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      lane_q       <= 2'd0;
      partial_q    <= 24'd0;
      word_count_q <= 6'd0;
      target_q     <= 6'd0;
    end else begin
      state_q      <= state_d;
      lane_q       <= lane_d;
      partial_q    <= partial_d;
      word_count_q <= word_count_d;
      target_q     <= target_d;
    end
  end

  // Memory is deliberately left out of reset; stale words are hidden by the word_count gate.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) mem_q[word_count_q[4:0]] <= mem_wdata;
  end

  assign rd_idx         = pc[6:2];
  assign unused_pc_bits = {pc[31:7], pc[1:0]};
  assign instruction    = (done && ({1'b0, rd_idx} < word_count_q)) ? mem_q[rd_idx] : 32'h0;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic [31:0] pc = 32'h0;
  logic [31:0] instruction;
  logic        loading;
  logic        done;
  logic [5:0]  word_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] exp;
  } rd_vec_t;

  rd_vec_t vecs [8];

  always #5 clk = ~clk;

  imem_loader dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .pc(pc), .instruction(instruction), .loading(loading),
    .done(done), .word_count(word_count)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input bit chk_ready);
    int n;
    in_valid = 1'b0;
    for (int i = 0; i < gap; i++) begin
      tick();
      if (chk_ready) check("in_ready_during_bubble", {31'd0, in_ready}, 32'd1);
    end
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    if (n == 20) check("byte_accept_timeout", 32'd0, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap, input bit chk_ready);
    send_byte(w[7:0],   gap, chk_ready);
    send_byte(w[15:8],  gap, chk_ready);
    send_byte(w[23:16], gap, chk_ready);
    send_byte(w[31:24], gap, chk_ready);
  endtask

  task automatic read_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
    pc = addr;
    #1;
    check(name, instruction, exp);
  endtask

  task automatic single_word_checks(input string tag);
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_loading"}, {31'd0, loading}, 32'd0);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    check({tag, "_word_count"}, {26'd0, word_count}, 32'd1);
    read_check({tag, "_pc0"}, 32'h0, 32'h005303B3);
    read_check({tag, "_pc4"}, 32'h4, 32'h0);
  endtask

  initial begin
    vecs[0] = '{32'h0000_0000, 32'h1000_0000};
    vecs[1] = '{32'h0000_0004, 32'h1000_0001};
    vecs[2] = '{32'h0000_007C, 32'h1000_001F};
    vecs[3] = '{32'h0000_0080, 32'h1000_0000};
    vecs[4] = '{32'h0000_007F, 32'h1000_001F};
    vecs[5] = '{32'hFFFF_FF84, 32'h1000_0001};
    vecs[6] = '{32'h0000_0040, 32'h1000_0010};
    vecs[7] = '{32'h0000_0036, 32'h1000_000D};

    // Reset held two cycles with start and a byte offered: reset must win.
    reset = 1'b1; start = 1'b1; in_valid = 1'b1; in_data = 8'h01;
    tick(); tick();
    reset = 1'b0; start = 1'b0;
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_loading", {31'd0, loading}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_word_count", {26'd0, word_count}, 32'd0);
    read_check("rst_instr_pc0", 32'h0, 32'h0);
    tick();
    check("idle_byte_not_consumed", {31'd0, in_ready}, 32'd0);
    check("idle_stays_idle", {31'd0, loading}, 32'd0);
    in_valid = 1'b0;

    // Single word, back-to-back bytes.
    pulse_start();
    check("header_loading", {31'd0, loading}, 32'd1);
    send_byte(8'h01, 0, 1'b0);
    send_byte(8'hB3, 0, 1'b0);
    send_byte(8'h03, 0, 1'b0);
    send_byte(8'h53, 0, 1'b0);
    check("pre_last_not_done", {31'd0, done}, 32'd0);
    send_byte(8'h00, 0, 1'b0);
    single_word_checks("single");

    // Same stream with 1..3 idle cycles between bytes.
    pulse_start();
    send_byte(8'h01, 1, 1'b1);
    send_byte(8'hB3, 1, 1'b1);
    send_byte(8'h03, 2, 1'b1);
    send_byte(8'h53, 3, 1'b1);
    send_byte(8'h00, 2, 1'b1);
    single_word_checks("bubble");

    // Full 32-word load, then table-driven fetches.
    pulse_start();
    send_byte(8'h00, 0, 1'b0);
    for (int i = 0; i < 32; i++) begin
      send_word(32'h1000_0000 + i, 0, 1'b0);
      if (i == 30) check("full_not_done_at_31", {31'd0, done}, 32'd0);
    end
    check("full_done", {31'd0, done}, 32'd1);
    check("full_word_count", {26'd0, word_count}, 32'd32);
    for (int i = 0; i < 8; i++) read_check($sformatf("full_read_%0d", i), vecs[i].pc, vecs[i].exp);

    // Reset in the middle of a load discards progress.
    pulse_start();
    send_byte(8'h02, 0, 1'b0);
    for (int i = 0; i < 6; i++) send_byte(8'hA0 + i[7:0], 0, 1'b0);
    check("midload_word_count", {26'd0, word_count}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_loading", {31'd0, loading}, 32'd0);
    check("midrst_word_count", {26'd0, word_count}, 32'd0);
    read_check("midrst_instr", 32'h0, 32'h0);
    pulse_start();
    send_byte(8'hE1, 0, 1'b0);
    send_word(32'h005303B3, 0, 1'b0);
    single_word_checks("after_rst");

    // start during LOAD is ignored.
    pulse_start();
    send_byte(8'h01, 0, 1'b0);
    send_byte(8'hB3, 0, 1'b0);
    send_byte(8'h03, 0, 1'b0);
    pulse_start();
    check("start_in_load_loading", {31'd0, loading}, 32'd1);
    check("start_in_load_wc", {26'd0, word_count}, 32'd0);
    send_byte(8'h53, 0, 1'b0);
    send_byte(8'h00, 0, 1'b0);
    single_word_checks("start_in_load");

    // start in DONE clears visibility until the reload completes.
    pulse_start();
    check("reload_done_fell", {31'd0, done}, 32'd0);
    check("reload_wc_cleared", {26'd0, word_count}, 32'd0);
    read_check("reload_hidden_pc0", 32'h0, 32'h0);
    send_byte(8'h02, 0, 1'b0);
    send_word(32'h1122_3344, 0, 1'b0);
    check("reload_partial_wc", {26'd0, word_count}, 32'd1);
    read_check("reload_partial_hidden", 32'h0, 32'h0);
    send_word(32'hCAFE_F00D, 1, 1'b1);
    check("reload_done", {31'd0, done}, 32'd1);
    check("reload_wc", {26'd0, word_count}, 32'd2);
    read_check("reload_pc0", 32'h0, 32'h1122_3344);
    read_check("reload_pc4", 32'h4, 32'hCAFE_F00D);
    read_check("reload_pc8_stale_hidden", 32'h8, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
